// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W).
//   Decides stall/flush controls for a single cycle from the current stage
//   contents and a small memory-wait FSM.
//
//   Ports
//     clk, rst_n              core clock, asynchronous active-low reset
//     rs1D, rs2D              D-stage source registers
//     use_rs1D, use_rs2D      D instruction really reads rs1 / rs2
//     rdE, reg_writeE         E-stage destination and write enable
//     mem_loadE               E load type (0 = not a load)
//     rdM, reg_writeM         M-stage destination and write enable
//     mem_loadM               M load type (0 = not a load)
//     mem_reqM, mem_readyM    M-stage data memory request / completion
//     branch_takenE           E-stage branch or jump redirects the PC
//     stallF/D/E/M            hold the PC and the F/D, D/E, E/M registers
//     flushD/E                clear the F/D or D/E register to a NOP
//     mem_err                 sticky memory-timeout error
//     lu_cnt, mw_cnt, fl_cnt  saturating load-use / mem-wait / flush counters
//     dbgState                current FSM state (RUN=0, MEM_WAIT=1, ERR=2)
//
//   Memory handshake: mem_reqM is held high by M for as long as its access
//   is outstanding; the access completes in the cycle where mem_readyM is
//   also high. A cycle with mem_reqM=1 and mem_readyM=0 is a wait cycle, and
//   the whole pipe is frozen for it.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic             use_rs1D,
    input  logic             use_rs2D,
    input  logic [4:0]       rdE,
    input  logic             reg_writeE,
    input  logic [2:0]       mem_loadE,
    input  logic [4:0]       rdM,
    input  logic             reg_writeM,
    input  logic [2:0]       mem_loadM,
    input  logic             mem_reqM,
    input  logic             mem_readyM,
    input  logic             branch_takenE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             mem_err,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mw_cnt,
    output logic [CNT_W-1:0] fl_cnt,
    output logic [1:0]       dbgState
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } stateT;

    stateT         state;
    logic [TW-1:0] timer;

    logic loadE, loadM;
    logic mE, mM, lu, mw;
    logic ruleMw, ruleBr, ruleLu;

    // Only a real load into a non-zero register is a hazard source: non-load
    // results in M are forwarded to D, and x0 never carries a value.
    assign loadE = reg_writeE & (mem_loadE != 3'b000) & (rdE != 5'd0);
    assign loadM = reg_writeM & (mem_loadM != 3'b000) & (rdM != 5'd0);

    assign mE = loadE & ((use_rs1D & (rs1D == rdE)) | (use_rs2D & (rs2D == rdE)));
    assign mM = loadM & ((use_rs1D & (rs1D == rdM)) | (use_rs2D & (rs2D == rdM)));
    assign lu = mE | mM;
    assign mw = mem_reqM & ~mem_readyM;

    // Priority chain. Everything is forced low while reset is asserted so the
    // pipe is never frozen by stale inputs during reset.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        ruleMw = 1'b0;
        ruleBr = 1'b0;
        ruleLu = 1'b0;
        if (!rst_n) begin
            // all outputs stay low
        end else if (state == ERR) begin
            {stallF, stallD, stallE, stallM} = 4'b1111;
        end else if (mw) begin
            // A pending branch flush waits: E is held, so the branch is
            // seen again once the memory completes.
            {stallF, stallD, stallE, stallM} = 4'b1111;
            ruleMw = 1'b1;
        end else if (branch_takenE) begin
            // The dependent D instruction is squashed, so no load-use stall.
            flushD = 1'b1;
            flushE = 1'b1;
            ruleBr = 1'b1;
        end else if (lu) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
            ruleLu = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            timer  <= '0;
            lu_cnt <= '0;
            mw_cnt <= '0;
            fl_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mw) begin
                        state <= MEM_WAIT;
                        timer <= TW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mw) begin
                        if (timer == TIMEOUT_V) begin
                            state <= ERR;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end else begin
                        state <= RUN;
                        timer <= '0;
                    end
                end
                ERR: begin
                    // held until reset
                end
                default: begin
                    state <= RUN;
                    timer <= '0;
                end
            endcase

            if (ruleLu && (lu_cnt != '1)) lu_cnt <= lu_cnt + CNT_W'(1);
            if (ruleMw && (mw_cnt != '1)) mw_cnt <= mw_cnt + CNT_W'(1);
            if (ruleBr && (fl_cnt != '1)) fl_cnt <= fl_cnt + CNT_W'(1);
        end
    end

    assign mem_err  = (state == ERR);
    assign dbgState = state;

endmodule
